burst_err_channel: RTL

- Parametrised corrupting channel between the convolutional encoder and the Viterbi decoder.
- Injects configurable bit errors into the encoded symbol stream, either periodic bursts or pseudo-random bursts.
- Forwards each symbol with its valid flag after one registered stage.
- Keeps saturating statistics counters for BER and decoder-robustness experiments.

---
 rtl/chan_pkg.sv | 29 ++
 rtl/chan_lfsr.sv | 34 +++
 rtl/burst_err_channel.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/chan_pkg.sv
// Shared types, LFSR polynomial and saturating arithmetic for the burst error channel.
package chan_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_RSVD     = 2'd3
    } chan_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } chan_state_t;

    // Right-shifting Galois taps for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        logic [31:0] res;
        sum = {1'b0, acc} + {1'b0, inc};
        res = (sum > {1'b0, max_val}) ? max_val : sum[31:0];
        return res;
    endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 16-bit Galois LFSR that steps only when adv_i is high; exposes its low OUT_W bits.
module chan_lfsr
    import chan_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/burst_err_channel.sv
// Corrupting channel: XOR-injects periodic or LFSR-driven error bursts into a symbol stream.
// Optional BURST_CNT_EN enables the bursts-started counter on burst_ct_o.
module burst_err_channel
    import chan_pkg::*;
#(
    parameter int          W        = 2,
    parameter int          PER_LOG2 = 3,
    parameter int          BL_W     = 3,
    parameter int          CNT_W    = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PER_LOG2-1:0] cfg_offset_i,
    input  logic [BL_W-1:0]     cfg_blen_i,
    input  logic [W-1:0]        cfg_mask_i,
    input  logic                sym_valid_i,
    input  logic [W-1:0]        sym_i,
    output logic                sym_valid_o,
    output logic [W-1:0]        sym_o,
    output logic [W-1:0]        err_o,
    output logic [CNT_W-1:0]    bit_err_ct_o,
    output logic [CNT_W-1:0]    sym_ct_o,
    output logic [CNT_W-1:0]    burst_ct_o
);

    localparam logic [CNT_W-1:0]    CNT_MAX = '1;
    localparam logic [PER_LOG2-1:0] POS_ONE = PER_LOG2'(1);
    localparam logic [BL_W-1:0]     REM_ONE = BL_W'(1);
    localparam int                  PERIOD  = 2 ** PER_LOG2;

    chan_mode_t          mode;
    chan_state_t         state_q, state_d;
    logic [PER_LOG2-1:0] pos_q, pos_d;
    logic [PER_LOG2-1:0] lfsr_low;
    logic [BL_W-1:0]     rem_q, rem_d;
    logic                hit, start_ok, corrupt, adv, mode_active, covers;
    logic [W-1:0]        err_d, sym_d, err_q, sym_q;
    logic                valid_q;
    logic [CNT_W-1:0]    bit_ct_q, bit_ct_d, sym_ct_q, sym_ct_d;
    logic [31:0]         pop;

    assign mode        = chan_mode_t'(cfg_mode_i);
    assign adv         = sym_valid_i && !clr_i;
    assign mode_active = (mode == MODE_PERIODIC) || (mode == MODE_RANDOM);
    // A burst at least one period long would otherwise skip positions; retrigger on every IDLE symbol.
    assign covers      = (32'(cfg_blen_i) >= 32'(PERIOD));
    assign start_ok    = hit && (cfg_blen_i != '0);

    chan_lfsr #(
        .SEED  (SEED),
        .OUT_W (PER_LOG2)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (adv),
        .lfsr_o (lfsr_low)
    );

    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_PERIODIC: hit = (pos_q == cfg_offset_i) || covers;
            MODE_RANDOM:   hit = (lfsr_low == '0);
            default:       hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        corrupt = 1'b0;
        if (clr_i) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            pos_d   = '0;
        end else if (sym_valid_i) begin
            pos_d = pos_q + POS_ONE;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        corrupt = 1'b1;
                        rem_d   = cfg_blen_i - REM_ONE;
                        if (cfg_blen_i != REM_ONE) begin
                            state_d = ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (!mode_active) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end else begin
                        corrupt = 1'b1;
                        rem_d   = rem_q - REM_ONE;
                        if (rem_q == REM_ONE) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        err_d = corrupt ? cfg_mask_i : '0;
        sym_d = sym_i ^ err_d;
        pop   = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + 32'(err_d[i]);
        end
        bit_ct_d = bit_ct_q;
        sym_ct_d = sym_ct_q;
        if (clr_i) begin
            bit_ct_d = '0;
            sym_ct_d = '0;
        end else if (sym_valid_i) begin
            bit_ct_d = CNT_W'(sat_add(32'(bit_ct_q), pop, 32'(CNT_MAX)));
            sym_ct_d = CNT_W'(sat_add(32'(sym_ct_q), 32'd1, 32'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
            sym_q    <= '0;
            err_q    <= '0;
            bit_ct_q <= '0;
            sym_ct_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            rem_q    <= rem_d;
            valid_q  <= sym_valid_i;
            bit_ct_q <= bit_ct_d;
            sym_ct_q <= sym_ct_d;
            // Data outputs hold across gaps; a clear still wipes the reported error pattern.
            if (sym_valid_i) begin
                sym_q <= sym_d;
                err_q <= err_d;
            end else if (clr_i) begin
                err_q <= '0;
            end
        end
    end

`ifdef BURST_CNT_EN
    logic [CNT_W-1:0] burst_ct_q;
    logic             trigger;

    assign trigger = adv && (state_q == ST_IDLE) && start_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_ct_q <= '0;
        end else if (clr_i) begin
            burst_ct_q <= '0;
        end else if (trigger) begin
            burst_ct_q <= CNT_W'(sat_add(32'(burst_ct_q), 32'd1, 32'(CNT_MAX)));
        end
    end

    assign burst_ct_o = burst_ct_q;
`else
    assign burst_ct_o = '0;
`endif

    assign sym_valid_o  = valid_q;
    assign sym_o        = sym_q;
    assign err_o        = err_q;
    assign bit_err_ct_o = bit_ct_q;
    assign sym_ct_o     = sym_ct_q;

endmodule
